universal_register: RTL and testbench
=====================================

# universal_register

Parametrised universal register, the successor to the fixed 8-bit load/hold register. It extends load and hold with clear, multi-bit logical, arithmetic and rotate shifts, serial in/out, and a start/busy/done handshake. Shift operations execute one bit per clock under a small control FSM. It sits wherever the datapath needs a holding register that can also serialise or shift data.

## Interface
- WIDTH, 8: register width; at least 2.
- AMT_W, $clog2(WIDTH+1): width of the shift amount (derived; do not override).
- CLK  in  1  clock; rising edge.
- RST  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  operation code, sampled with start.
- amt  in  AMT_W  shift count, sampled with start; values above WIDTH clamp to WIDTH.
- data_in  in  WIDTH  parallel load data.
- ser_in  in  1  serial fill bit for SHL/SHR, sampled every shift cycle.
- data_out  out  WIDTH  register contents.
- ser_out  out  1  last bit shifted or rotated out (registered).
- busy  out  1  shift in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- Op codes: 0 NOP, 1 LOAD, 2 CLEAR, 3 SHL (ser_in enters at bit 0), 4 SHR (ser_in enters at MSB), 5 ASR (MSB replicated), 6 ROL, 7 ROR.
- FSM states: IDLE, SHIFT.
- IDLE + start + NOP/LOAD/CLEAR:
  - Register updated at the accepting edge (LOAD: data_in; CLEAR: 0; NOP: unchanged).
  - done=1 for the next cycle; stay in IDLE.
- IDLE + start + shift op with amt=0: behaves as NOP; done pulses, no data change.
- IDLE + start + shift op with amt=k>0:
  - Op and clamped k captured at the accepting edge; go to SHIFT with counter=k; data unchanged at that edge.
  - Each SHIFT edge: shift/rotate by one bit, update ser_out, decrement the counter.
  - On the edge where the counter goes 1->0: return to IDLE and set done=1 for one cycle.
- start while busy=1 is ignored; op, amt and data_in changes during SHIFT have no effect.
- start in the cycle done=1 is accepted, so back-to-back operations are allowed.
- ser_out: SHL takes the old MSB; SHR/ASR take the old bit 0; ROL/ROR take the rotated bit. Unchanged by LOAD, CLEAR and NOP.
- Width rule: shift amount WIDTH gives SHL/SHR = the WIDTH-bit ser_in history; ASR = all sign; rotate = original value.

## Timing
- Reset (RST=0, asynchronous, any state including mid-SHIFT): data_out=0, ser_out=0, busy=0, done=0, state IDLE, counter=0. Normal operation resumes on the first edge after RST returns high.
- LOAD/CLEAR/NOP latency: data visible 1 edge after start; done high in the same cycle.
- Shift latency: busy high for k cycles starting the cycle after acceptance; final data and done appear k+1 edges after start.
- All outputs are registered except the optional parity.

## Configuration
- UNIVERSAL_REGISTER_PARITY_EN defined: adds output port parity (1 bit), combinational even parity (XOR-reduce) of data_out; reset value 0, following data_out.
- Macro undefined: the parity port and its logic are absent; all other behaviour is identical.

## Structure
- Package universal_register_pkg:
  - op-code enum: NOP, LOAD, CLEAR, SHL, SHR, ASR, ROL, ROR.
  - FSM state enum: IDLE, SHIFT.
  - function computing the one-bit shift result and ser_out for a given op.
- Sub-module universal_register_ctrl:
  - contains the FSM, the amount counter with clamping, and busy/done generation;
  - drives a shift-enable strobe to the datapath in the top level.

## Test plan
- Reset mid-shift: WIDTH=8, LOAD 0xA5, SHL amt=5; pull RST low on the 2nd busy cycle -> data_out=0x00, busy=0, done=0 immediately. After release, NOP -> done pulse, data 0x00.
- LOAD/ROL: LOAD 0x81, then ROL amt=1 -> data_out=0x03, ser_out=1, done 2 edges after start.
- ASR: LOAD 0x90, ASR amt=3 -> busy for 3 cycles, then data_out=0xF2, ser_out=0.
- Serial fill: LOAD 0x00, SHR amt=8 with ser_in=1,0,1,1,0,0,1,0 on successive cycles -> data_out=0x4D.
- Clamp and zero amount: WIDTH=6, amt=7 with ROR on 0x2B -> clamped to 6, busy 6 cycles, data_out=0x2B. SHL amt=0 -> done after 1 edge, data unchanged.
- Handshake: start held high with LOAD during a shift -> ignored. start held on the done cycle -> next op accepted with no idle gap. With the parity macro on, after LOAD 0x07 -> parity=1.

Source files
------------

// File: rtl/universal_register_pkg.sv
// Shared types for universal_register: op codes, FSM states and the one-bit shift step.
// The step is width-agnostic: it says which way to shift, which bit fills the gap and which bit leaves.
package universal_register_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    SHL   = 3'd3,
    SHR   = 3'd4,
    ASR   = 3'd5,
    ROL   = 3'd6,
    ROR   = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic left;
    logic fill;
    logic sout;
  } step_t;

  function automatic step_t shift_step(op_e op, logic msb, logic lsb, logic sin);
    step_t s;
    s = '{left: 1'b0, fill: sin, sout: lsb};
    case (op)
      SHL:     s = '{left: 1'b1, fill: sin, sout: msb};
      SHR:     s = '{left: 1'b0, fill: sin, sout: lsb};
      ASR:     s = '{left: 1'b0, fill: msb, sout: lsb};
      ROL:     s = '{left: 1'b1, fill: msb, sout: msb};
      ROR:     s = '{left: 1'b0, fill: lsb, sout: lsb};
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/universal_register_ctrl.sv
// Control FSM for universal_register: accepts requests, clamps and counts the shift amount,
// and produces busy, the done pulse and the per-cycle shift strobe.
module universal_register_ctrl
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_start,
  input  op_e              i_op,
  input  logic [AMT_W-1:0] i_amt,
  output logic             o_accept,
  output logic             o_shift_en,
  output op_e              o_op,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(WIDTH);

  state_e           r_state;
  logic [AMT_W-1:0] r_cnt;
  op_e              r_op;
  logic             r_done;
  logic [AMT_W-1:0] w_amt;
  logic             w_shift_req;

  assign w_amt       = (i_amt > MAX_AMT) ? MAX_AMT : i_amt;
  assign o_accept    = i_start && (r_state == IDLE);
  // A shift with a zero count is treated as a NOP: done pulses, no SHIFT visit.
  assign w_shift_req = o_accept && (i_op >= SHL) && (w_amt != '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= NOP;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_shift_req) begin
            r_state <= SHIFT;
            r_cnt   <= w_amt;
            r_op    <= i_op;
          end else if (o_accept) begin
            r_done  <= 1'b1;
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_shift_en = (r_state == SHIFT);
  assign o_busy     = (r_state == SHIFT);
  assign o_op       = r_op;
  assign o_done     = r_done;

endmodule

// File: rtl/universal_register.sv
// Parametrised universal register: load/clear/hold plus bit-serial shifts and rotates.
// Defining UNIVERSAL_REGISTER_PARITY_EN adds a combinational even-parity output of data_out.
module universal_register
  import universal_register_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
`ifdef UNIVERSAL_REGISTER_PARITY_EN
  output logic             parity,
`endif
  output logic             done
);

  logic [WIDTH-1:0] r_data;
  logic             r_sout;
  logic             w_accept;
  logic             w_shift_en;
  op_e              w_op;
  step_t            w_step;
  logic [WIDTH-1:0] w_shifted;

  universal_register_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_ctrl (
    .CLK        (CLK),
    .RST        (RST),
    .i_start    (start),
    .i_op       (op_e'(op)),
    .i_amt      (amt),
    .o_accept   (w_accept),
    .o_shift_en (w_shift_en),
    .o_op       (w_op),
    .o_busy     (busy),
    .o_done     (done)
  );

  assign w_step    = shift_step(w_op, r_data[WIDTH-1], r_data[0], ser_in);
  assign w_shifted = w_step.left ? {r_data[WIDTH-2:0], w_step.fill}
                                 : {w_step.fill, r_data[WIDTH-1:1]};

  // Shift strobe and acceptance are mutually exclusive (accept needs IDLE).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data <= '0;
      r_sout <= 1'b0;
    end else if (w_shift_en) begin
      r_data <= w_shifted;
      r_sout <= w_step.sout;
    end else if (w_accept) begin
      case (op_e'(op))
        LOAD:    r_data <= data_in;
        CLEAR:   r_data <= '0;
        default: ;
      endcase
    end
  end

  assign data_out = r_data;
  assign ser_out  = r_sout;

`ifdef UNIVERSAL_REGISTER_PARITY_EN
  assign parity = ^r_data;
`endif

endmodule

// File: tb/tb_universal_register.sv
// Randomized bench for universal_register (WIDTH=8) plus a directed WIDTH=6 clamp check,
// against a reference that computes whole-operation results arithmetically.
module tb_universal_register;

  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0, ser_in = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] amt = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       ser_out, busy, done;

  logic       start6 = 1'b0, ser6 = 1'b0;
  logic [2:0] op6 = '0, amt6 = '0;
  logic [5:0] din6 = '0;
  logic [5:0] dout6;
  logic       sout6, busy6, done6;

`ifdef UNIVERSAL_REGISTER_PARITY_EN
  logic par, par6;
`endif

  always #5 CLK = ~CLK;

  universal_register #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .amt(amt), .data_in(data_in),
    .ser_in(ser_in), .data_out(data_out), .ser_out(ser_out), .busy(busy),
`ifdef UNIVERSAL_REGISTER_PARITY_EN
    .parity(par),
`endif
    .done(done)
  );

  universal_register #(.WIDTH(6)) dut6 (
    .CLK(CLK), .RST(RST), .start(start6), .op(op6), .amt(amt6), .data_in(din6),
    .ser_in(ser6), .data_out(dout6), .ser_out(sout6), .busy(busy6),
`ifdef UNIVERSAL_REGISTER_PARITY_EN
    .parity(par6),
`endif
    .done(done6)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] m_data = '0;
  logic       m_sout = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Whole-operation result for a k-bit shift; hist[i] is ser_in at the i-th shift edge.
  function automatic logic [8:0] model_shift(input int opc, input logic [7:0] d, input int k,
                                              input logic [7:0] hist);
    int   dv, res, fill;
    logic s;
    dv = int'(d);
    fill = 0;
    res = dv;
    s = 1'b0;
    case (opc)
      3: begin
        for (int i = 0; i < k; i++) fill |= int'(hist[i]) << (k - 1 - i);
        res = (dv << k) | fill;
        s = d[W-k];
      end
      4: begin
        for (int i = 0; i < k; i++) fill |= int'(hist[i]) << (W - k + i);
        res = (dv >> k) | fill;
        s = d[k-1];
      end
      5: begin
        res = ((dv ^ 128) - 128) >>> k;
        s = d[k-1];
      end
      6: begin
        res = (dv << k) | (dv >> (W - k));
        s = d[W-k];
      end
      7: begin
        res = (dv >> k) | (dv << (W - k));
        s = d[k-1];
      end
      default: ;
    endcase
    return {s, res[7:0]};
  endfunction

  // Issues one request at the current cycle and returns in its done cycle.
  task automatic do_op(input int opc, input int a, input logic [7:0] d, input logic [7:0] hist,
                       input bit poke);
    int         k;
    logic [8:0] r;
    k = (opc >= 3) ? ((a > W) ? W : a) : 0;
    start = 1'b1; op = opc[2:0]; amt = a[3:0]; data_in = d; ser_in = 1'($urandom_range(1));
    tick();
    start = 1'b0;
    if (k == 0) begin
      if (opc == 1) m_data = d;
      else if (opc == 2) m_data = '0;
      chk("done_imm", {31'd0, done}, 1);
      chk("busy_imm", {31'd0, busy}, 0);
    end else begin
      r = model_shift(opc, m_data, k, hist);
      chk("data_hold", {24'd0, data_out}, {24'd0, m_data});
      for (int i = 0; i < k; i++) begin
        chk("busy", {31'd0, busy}, 1);
        chk("done_busy", {31'd0, done}, 0);
        ser_in = hist[i];
        if (poke) begin
          start = 1'b1; op = 3'd1; data_in = 8'($urandom); amt = 4'($urandom);
        end
        tick();
      end
      start = 1'b0;
      m_data = r[7:0];
      m_sout = r[8];
      chk("done_shift", {31'd0, done}, 1);
      chk("busy_end", {31'd0, busy}, 0);
    end
    chk("data", {24'd0, data_out}, {24'd0, m_data});
    chk("sout", {31'd0, ser_out}, {31'd0, m_sout});
`ifdef UNIVERSAL_REGISTER_PARITY_EN
    chk("parity", {31'd0, par}, {31'd0, ^m_data});
`endif
  endtask

  initial begin
    int n;
    int opc, a;
    logic [7:0] d, h;

    #12;
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sout", {31'd0, ser_out}, 0);
    chk("rst_data6", {26'd0, dout6}, 0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // WIDTH=6: amount 7 clamps to 6, so a full rotate restores the value.
    din6 = 6'h2B; op6 = 3'd1; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    chk("w6_load", {26'd0, dout6}, 32'h2B);
    op6 = 3'd7; amt6 = 3'd7; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    n = 0;
    while (busy6 && n < 20) begin
      n++;
      tick();
    end
    chk("w6_busy_cycles", n, 6);
    chk("w6_data", {26'd0, dout6}, 32'h2B);
    chk("w6_done", {31'd0, done6}, 1);
    chk("w6_sout", {31'd0, sout6}, 1);
    op6 = 3'd3; amt6 = 3'd0; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    chk("w6_zero_done", {31'd0, done6}, 1);
    chk("w6_zero_data", {26'd0, dout6}, 32'h2B);
    tick();

    do_op(1, 0, 8'h81, 8'h00, 1'b0);
    do_op(6, 1, 8'h00, 8'h00, 1'b0);
    chk("rol_data", {24'd0, data_out}, 32'h03);
    chk("rol_sout", {31'd0, ser_out}, 1);
    do_op(1, 0, 8'h90, 8'h00, 1'b0);
    do_op(5, 3, 8'h00, 8'h00, 1'b0);
    chk("asr_data", {24'd0, data_out}, 32'hF2);
    chk("asr_sout", {31'd0, ser_out}, 0);
    do_op(1, 0, 8'h00, 8'h00, 1'b0);
    do_op(4, 8, 8'h00, 8'b0100_1101, 1'b0);
    chk("shr_fill", {24'd0, data_out}, 32'h4D);
    do_op(3, 0, 8'h00, 8'h00, 1'b0);
    chk("shl_zero", {24'd0, data_out}, 32'h4D);
    do_op(1, 0, 8'h07, 8'h00, 1'b0);
    do_op(3, 3, 8'h00, 8'hA5, 1'b1);

    repeat (60) begin
      opc = $urandom_range(7);
      a   = $urandom_range(15);
      d   = 8'($urandom);
      h   = 8'($urandom);
      do_op(opc, a, d, h, 1'($urandom_range(1)));
      if ($urandom_range(2) == 0) begin
        tick();
        chk("idle_done", {31'd0, done}, 0);
        chk("idle_data", {24'd0, data_out}, {24'd0, m_data});
      end
    end

    do_op(1, 0, 8'hA5, 8'h00, 1'b0);
    start = 1'b1; op = 3'd3; amt = 4'd5;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy", {31'd0, busy}, 1);
    RST = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, data_out}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_sout", {31'd0, ser_out}, 0);
    @(negedge CLK);
    RST = 1'b1;
    m_data = '0;
    m_sout = 1'b0;
    tick();
    do_op(0, 0, 8'hFF, 8'h00, 1'b0);
    chk("post_rst_nop", {24'd0, data_out}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
